// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces the run/hour/minute buttons, toggles the
// run enable on each run press, and turns held adjust keys into single and auto-repeat pulses.

module kc_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_i,
   output logic stable_o,
   output logic prev_o
);
   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d, prev_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronized key disagrees with the accepted level.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) stable_d = sync2_q;
         else                   cnt_d    = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= key_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         prev_q   <= stable_q;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;
   assign prev_o   = prev_q;
endmodule

module kc_repeat #(
   parameter int unsigned REPEAT_DELAY_CYCLES = 50_000_000,
   parameter int unsigned REPEAT_RATE_CYCLES  = 10_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stable_i,
   input  logic prev_i,
   output logic pulse_o
);
   // Intervals below 2 would put pulses on back-to-back cycles, so they are clamped.
   localparam int unsigned DLY  = (REPEAT_DELAY_CYCLES < 2) ? 2 : REPEAT_DELAY_CYCLES;
   localparam int unsigned RATE = (REPEAT_RATE_CYCLES < 2) ? 2 : REPEAT_RATE_CYCLES;
   localparam int unsigned MAXC = (DLY > RATE) ? DLY : RATE;
   localparam int unsigned CW   = $clog2(MAXC);
   localparam logic [CW-1:0] DLY_LAST  = CW'(DLY - 1);
   localparam logic [CW-1:0] RATE_LAST = CW'(RATE - 1);

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          pulse_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (stable_i && !prev_i) begin
                  pulse_q <= 1'b1;
                  state_q <= S_DELAY;
               end
            end
            S_DELAY: begin
               if (!stable_i) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == DLY_LAST) begin
                  pulse_q <= 1'b1;
                  state_q <= S_REPEAT;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_REPEAT: begin
               if (!stable_i) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == RATE_LAST) begin
                  pulse_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign pulse_o = pulse_q;
endmodule

module key_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES     = 1_000_000,
   parameter int unsigned REPEAT_DELAY_CYCLES = 50_000_000,
   parameter int unsigned REPEAT_RATE_CYCLES  = 10_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_run,
   input  logic key_hour,
   input  logic key_minute,
   output logic en,
   output logic adjust_hour,
   output logic adjust_minute
);
   logic run_stable, run_prev, hour_stable, hour_prev, min_stable, min_prev;
   logic run_rise_q, en_q;

   kc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
      .clk(clk), .rst_n(rst_n), .key_i(key_run), .stable_o(run_stable), .prev_o(run_prev)
   );
   kc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hour (
      .clk(clk), .rst_n(rst_n), .key_i(key_hour), .stable_o(hour_stable), .prev_o(hour_prev)
   );
   kc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_minute (
      .clk(clk), .rst_n(rst_n), .key_i(key_minute), .stable_o(min_stable), .prev_o(min_prev)
   );

   kc_repeat #(
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
   ) u_rep_hour (
      .clk(clk), .rst_n(rst_n), .stable_i(hour_stable), .prev_i(hour_prev), .pulse_o(adjust_hour)
   );
   kc_repeat #(
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
   ) u_rep_minute (
      .clk(clk), .rst_n(rst_n), .stable_i(min_stable), .prev_i(min_prev), .pulse_o(adjust_minute)
   );

   // The run press is registered once before it flips the enable level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_rise_q <= 1'b0;
         en_q       <= 1'b1;
      end else begin
         run_rise_q <= run_stable & ~run_prev;
         if (run_rise_q) en_q <= ~en_q;
      end
   end

   assign en = en_q;
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with short debounce/repeat timing: table of key-press windows
// with expected per-cycle outputs, plus a hand sequence for reset in the middle of repeat.
`timescale 1ns/1ps
module tb_key_conditioner;
   localparam int DB = 4;
   localparam int DL = 20;
   localparam int RT = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic key_run = 1'b0, key_hour = 1'b0, key_minute = 1'b0;
   logic en, adjust_hour, adjust_minute;

   int total = 0;
   int bad   = 0;
   logic [2:0] exp_q[$];

   always #5 clk = ~clk;

   key_conditioner #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY_CYCLES(DL), .REPEAT_RATE_CYCLES(RT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_run(key_run), .key_hour(key_hour),
      .key_minute(key_minute), .en(en), .adjust_hour(adjust_hour),
      .adjust_minute(adjust_minute)
   );

   typedef struct {
      string name;
      int    len;
      int    h_on, h_off, m_on, m_off;
      int    r1_on, r1_off, r2_on, r2_off;
      bit    chk_glitch;
   } vec_t;

   vec_t vecs[7];

   function automatic bit in_win(int on, int off, int c);
      return (on >= 0) && (c >= on) && (c < off);
   endfunction

   // Key raised after edge 'on': pulses at on+7, then on+7+DL, then every RT, up to
   // the edge on which the release has finished debouncing (off+2+DB).
   function automatic bit adj_exp(int on, int off, int c);
      if (on < 0 || (off - on) < DB) return 1'b0;
      if (c > off + 2 + DB) return 1'b0;
      if (c == on + 7) return 1'b1;
      if (c >= on + 7 + DL && ((c - (on + 7 + DL)) % RT) == 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit en_exp(vec_t v, int c);
      bit e = 1'b1;
      if (v.r1_on >= 0 && (v.r1_off - v.r1_on) >= DB && c >= v.r1_on + 8) e = ~e;
      if (v.r2_on >= 0 && (v.r2_off - v.r2_on) >= DB && c >= v.r2_on + 8) e = ~e;
      return e;
   endfunction

   task automatic check(string nm, int c, logic [2:0] got, logic [2:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got(en,h,m)=%b want=%b", nm, c, got, want);
      end
   endtask

   task automatic do_reset();
      key_run = 1'b0; key_hour = 1'b0; key_minute = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("reset_async", -1, {en, adjust_hour, adjust_minute}, 3'b100);
      repeat (3) @(posedge clk);
      #1 check("reset_hold", -1, {en, adjust_hour, adjust_minute}, 3'b100);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic run_vec(vec_t v);
      logic [2:0] got, want;
      do_reset();
      for (int c = 0; c < v.len; c++) begin
         @(posedge clk);
         #1;
         exp_q.push_back({en_exp(v, c), adj_exp(v.h_on, v.h_off, c), adj_exp(v.m_on, v.m_off, c)});
         key_hour   = in_win(v.h_on, v.h_off, c);
         key_minute = in_win(v.m_on, v.m_off, c);
         key_run    = in_win(v.r1_on, v.r1_off, c) | in_win(v.r2_on, v.r2_off, c);
         got  = {en, adjust_hour, adjust_minute};
         want = exp_q.pop_front();
         check(v.name, c, got, want);
         if (v.chk_glitch)
            check("glitch_stable", c, {2'b00, dut.u_db_minute.stable_q}, 3'b000);
      end
      key_run = 1'b0; key_hour = 1'b0; key_minute = 1'b0;
   endtask

   initial begin
      vecs[0] = '{"hold10",  30,  0, 10, -1, -1, -1, -1, -1, -1, 1'b0};
      vecs[1] = '{"glitch3", 20, -1, -1,  0,  3, -1, -1, -1, -1, 1'b1};
      vecs[2] = '{"hold60",  80,  0, 60, -1, -1, -1, -1, -1, -1, 1'b0};
      vecs[3] = '{"run2x",   45, -1, -1, -1, -1,  0, 10, 20, 30, 1'b0};
      vecs[4] = '{"both",    30,  0, 12,  0, 12, -1, -1, -1, -1, 1'b0};
      vecs[5] = '{"adj_en0", 40, 20, 30, -1, -1,  0,  6, -1, -1, 1'b0};
      vecs[6] = '{"edge4_3", 25,  0,  4, 10, 13, -1, -1, -1, -1, 1'b0};

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Reset while the hour key is auto-repeating, with en already toggled low.
      do_reset();
      for (int c = 0; c <= 32; c++) begin
         @(posedge clk);
         #1;
         key_run  = (c < 6);
         key_hour = 1'b1;
         if (c == 20) check("rep_en_low", c, {en, adjust_hour, adjust_minute}, 3'b000);
         if (c == 31) check("rep_gap", c, {en, adjust_hour, adjust_minute}, 3'b000);
         if (c == 32) check("rep_pulse", c, {en, adjust_hour, adjust_minute}, 3'b010);
      end
      #1 rst_n = 1'b0;
      #1 check("rst_mid_repeat", -1, {en, adjust_hour, adjust_minute}, 3'b100);
      repeat (2) @(posedge clk);
      #1 check("rst_mid_hold", -1, {en, adjust_hour, adjust_minute}, 3'b100);
      rst_n = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         check("held_thru_reset", c, {en, adjust_hour, adjust_minute},
               (c == 7) ? 3'b110 : 3'b100);
      end
      key_hour = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
